// File: rtl/edlo_pkg.sv
// Shared constants, state encoding and helpers for the EDLO serial reader.
// Imported by the reader top and its bit timer.
package edlo_pkg;

    localparam int ENTRY_W    = 2;
    localparam int N_ENTRIES  = 4;
    localparam int ADDR_W     = 2;
    localparam int FRAME_BITS = 5;
    localparam int MEM_W      = ENTRY_W * N_ENTRIES;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Entry n lives at bits [2n+1:2n] of the packed word.
    function automatic logic [ENTRY_W-1:0] entry_sel(
        input logic [MEM_W-1:0]  word,
        input logic [ADDR_W-1:0] addr
    );
        return word[{addr, 1'b0} +: ENTRY_W];
    endfunction

endpackage

// File: rtl/edlo_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and
// flags the last cycle of each bit with a one-cycle tick.
module edlo_bit_timer
    import edlo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [7:0] TC = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_cnt;
    logic       w_term;

    assign w_term = (r_cnt == TC);
    assign o_tick = i_enable && !i_restart && w_term;

    // Cycle counter, cleared when idle, on restart and at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_restart || !i_enable || w_term) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/edlo_serial_reader.sv
// Serial readback of the EDLO 4x2-bit memory: snapshots the packed
// word on request and sends one or four start/data/parity/stop frames.
module edlo_serial_reader
    import edlo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MEM_W-1:0] mem_in,
    input  logic             rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic             rd_burst,
    output logic             sdo,
    output logic             rd_busy,
    output logic             rd_done
);

    localparam logic [ADDR_W-1:0] LAST_FRAME =
        ADDR_W'(N_ENTRIES - 1);

    state_t              r_state;
    logic [MEM_W-1:0]    r_snap;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_frames;
    logic                r_burst;
    logic                r_bit_lo;
    logic                r_sdo;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_enable;
    logic                w_tick;
    logic [ENTRY_W-1:0]  w_entry;

    assign w_accept = (r_state == ST_IDLE) && rd_req;
    assign w_enable = (r_state != ST_IDLE);
    assign w_entry  = entry_sel(r_snap, r_ptr);

    assign sdo     = r_sdo;
    assign rd_busy = r_busy;
    assign rd_done = r_done;

    edlo_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enable  (w_enable),
        .i_restart (w_accept),
        .o_tick    (w_tick)
    );

    // Frame sequencer: each output bit is registered one bit-time ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_snap   <= '0;
            r_ptr    <= '0;
            r_frames <= '0;
            r_burst  <= 1'b0;
            r_bit_lo <= 1'b0;
            r_sdo    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (rd_req) begin
                        r_snap   <= mem_in;
                        r_ptr    <= rd_addr;
                        r_burst  <= rd_burst;
                        r_frames <= '0;
                        r_state  <= ST_START;
                        r_sdo    <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state  <= ST_DATA;
                        r_bit_lo <= 1'b0;
                        r_sdo    <= w_entry[1];
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (!r_bit_lo) begin
                            r_bit_lo <= 1'b1;
                            r_sdo    <= w_entry[0];
                        end else begin
                            r_state <= ST_PARITY;
                            r_sdo   <= ^w_entry;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state <= ST_STOP;
                        r_sdo   <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_burst && (r_frames != LAST_FRAME)) begin
                            r_ptr    <= r_ptr + 1'b1;
                            r_frames <= r_frames + 1'b1;
                            r_state  <= ST_START;
                            r_sdo    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_sdo   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sdo   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
